du_tx_arbiter: RTL and testbench



---
 rtl/du_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_du_tx_arbiter.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/du_tx_arbiter.sv
// du_tx_arbiter: round-robin owner of the UART Tx FIFO write port.
// Grants whole frames, pulses tx start per frame, revokes stalled owners.
module du_tx_arbiter #(
  parameter int N_REQ        = 3,
  parameter int NB_UART_DATA = 8,
  parameter int NB_LEN       = 16,
  parameter int TIMEOUT      = 1024
) (
  input  logic                          clk,
  input  logic                          i_rst_n,
  input  logic [N_REQ-1:0]              i_req,
  input  logic [N_REQ-1:0]              i_valid,
  input  logic [N_REQ*NB_UART_DATA-1:0] i_data,
  input  logic [N_REQ-1:0]              i_last,
  input  logic                          i_tx_full,
  output logic [N_REQ-1:0]              o_ack,
  output logic [N_REQ-1:0]              o_grant,
  output logic                          o_wr,
  output logic [NB_UART_DATA-1:0]       o_wdata,
  output logic                          o_tx_start,
  output logic                          o_busy,
  output logic                          o_timeout,
  output logic [NB_LEN-1:0]             o_frame_len
);

  localparam int NB_IDX  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int NB_IDLE = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [NB_IDLE-1:0] IDLE_MAX = NB_IDLE'(TIMEOUT - 1);
  localparam logic [NB_IDX-1:0]  LAST_RST = NB_IDX'(N_REQ - 1);
  localparam logic [N_REQ-1:0]   ONE      = N_REQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    START
  } state_t;

  state_t               state;
  logic [NB_IDX-1:0]    last_grant;
  logic [NB_IDX-1:0]    owner;
  logic [NB_IDX-1:0]    pick;
  logic                 found;
  logic [NB_IDLE-1:0]   idle_cnt;
  logic                 own_req;
  logic                 own_valid;
  logic                 own_last;
  logic [NB_UART_DATA-1:0] own_data;
  logic                 in_grant;
  logic                 accept;
  logic                 abort;
  logic                 expire;

  // Search upward from the previous owner so every requester gets a turn.
  always_comb begin
    logic [NB_IDX-1:0] cand;
    found = 1'b0;
    pick  = last_grant;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = NB_IDX'((int'(last_grant) + i) % N_REQ);
      if (!found && i_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    own_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner == NB_IDX'(k))
        own_data = i_data[k*NB_UART_DATA +: NB_UART_DATA];
    end
  end

  assign own_req   = i_req[owner];
  assign own_valid = i_valid[owner];
  assign own_last  = i_last[owner];
  assign in_grant  = (state == GRANT);
  assign abort     = in_grant & ~own_req;
  assign accept    = in_grant & own_req & own_valid & ~i_tx_full;
  assign expire    = in_grant & own_req & ~accept
                   & (idle_cnt == IDLE_MAX);

  assign o_wr    = accept;
  assign o_wdata = accept ? own_data : '0;
  assign o_ack   = accept ? (ONE << owner) : '0;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      last_grant  <= LAST_RST;
      owner       <= '0;
      idle_cnt    <= '0;
      o_grant     <= '0;
      o_tx_start  <= 1'b0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
      o_frame_len <= '0;
    end else begin
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            owner       <= pick;
            last_grant  <= pick;
            o_grant     <= ONE << pick;
            o_frame_len <= '0;
            idle_cnt    <= '0;
            o_busy      <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (abort) begin
            o_grant <= '0;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end else if (accept) begin
            idle_cnt <= '0;
            if (o_frame_len != '1)
              o_frame_len <= o_frame_len + 1'b1;
            if (own_last) begin
              o_tx_start <= 1'b1;
              state      <= START;
            end
          end else if (expire) begin
            o_timeout <= 1'b1;
            o_grant   <= '0;
            o_busy    <= 1'b0;
            state     <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        START: begin
          o_grant <= '0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_du_tx_arbiter.sv
// tb_du_tx_arbiter: directed scenarios plus randomized multi-frame traffic
// checked against a frame-level round-robin model.
module tb_du_tx_arbiter;

  localparam int N  = 3;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] valid;
  logic [N-1:0] last;
  logic [N*8-1:0] data;
  logic         full;
  logic [N-1:0] ack;
  logic [N-1:0] grant;
  logic         wr;
  logic [7:0]   wdata;
  logic         tx_start;
  logic         busy;
  logic         timeout;
  logic [15:0]  frame_len;

  int total = 0;
  int bad   = 0;

  logic [7:0] fb [3][4][4];
  int         flen [3][4];
  int         nf [3];
  int         fi [3];
  int         bi [3];
  logic [7:0] exp_b [$];
  int         exp_k [$];
  int         exp_len [$];

  du_tx_arbiter #(
    .N_REQ(N), .NB_UART_DATA(8), .NB_LEN(16), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .i_rst_n(rst_n), .i_req(req), .i_valid(valid),
    .i_data(data), .i_last(last), .i_tx_full(full), .o_ack(ack),
    .o_grant(grant), .o_wr(wr), .o_wdata(wdata),
    .o_tx_start(tx_start), .o_busy(busy), .o_timeout(timeout),
    .o_frame_len(frame_len)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req   = '0;
    valid = '0;
    last  = '0;
    data  = '0;
    full  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    req   = 3'b111;
    valid = 3'b111;
    tick();
    tick();
    @(negedge clk);
    total++;
    if (grant !== 3'b000) begin
      bad++;
      $display("FAIL reset_grant: got %b want 000", grant);
    end
    total++;
    if ({wr, wdata, ack} !== 12'h000) begin
      bad++;
      $display("FAIL reset_wr: wr=%b data=%h ack=%b want 0", wr, wdata, ack);
    end
    total++;
    if ({tx_start, busy, timeout} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000",
               {tx_start, busy, timeout});
    end
    total++;
    if (frame_len !== 16'd0) begin
      bad++;
      $display("FAIL reset_len: got %0d want 0", frame_len);
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req   = 3'b010;
    valid = 3'b010;
    data[15:8] = 8'hAA;
    last  = 3'b000;
    @(negedge clk);
    total++;
    if (grant !== 3'b000) begin
      bad++;
      $display("FAIL single_latency: grant=%b want 000", grant);
    end
    tick();
    @(negedge clk);
    total++;
    if (grant !== 3'b010 || {wr, wdata} !== {1'b1, 8'hAA}
        || ack !== 3'b010) begin
      bad++;
      $display("FAIL single_b0: grant=%b wr=%b data=%h ack=%b want 010 1 aa 010",
               grant, wr, wdata, ack);
    end
    tick();
    data[15:8] = 8'hBB;
    @(negedge clk);
    total++;
    if ({wr, wdata} !== {1'b1, 8'hBB}) begin
      bad++;
      $display("FAIL single_b1: wr=%b data=%h want 1 bb", wr, wdata);
    end
    tick();
    data[15:8] = 8'hCC;
    last = 3'b010;
    @(negedge clk);
    total++;
    if ({wr, wdata} !== {1'b1, 8'hCC} || ack !== 3'b010) begin
      bad++;
      $display("FAIL single_b2: wr=%b data=%h ack=%b want 1 cc 010",
               wr, wdata, ack);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    total++;
    if (tx_start !== 1'b1 || frame_len !== 16'd3 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_start: start=%b len=%0d busy=%b want 1 3 1",
               tx_start, frame_len, busy);
    end
    tick();
    @(negedge clk);
    total++;
    if (tx_start !== 1'b0 || grant !== 3'b000 || frame_len !== 16'd3) begin
      bad++;
      $display("FAIL single_after: start=%b grant=%b len=%0d want 0 000 3",
               tx_start, grant, frame_len);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int c;
    int e;
    logic [2:0] oh;
    logic [7:0] eb;
    do_reset();
    req   = 3'b111;
    valid = 3'b111;
    last  = 3'b111;
    data  = {8'hC2, 8'hC1, 8'hC0};
    for (int f = 0; f < 9; f++) begin
      e  = f % 3;
      oh = 3'b001 << e;
      eb = 8'hC0 + 8'(e);
      c  = 0;
      @(negedge clk);
      while (!wr && c < 8) begin
        tick();
        @(negedge clk);
        c++;
      end
      total++;
      if (wr !== 1'b1 || ack !== oh || wdata !== eb) begin
        bad++;
        $display("FAIL rr_frame%0d: wr=%b ack=%b data=%h want 1 %b %h",
                 f, wr, ack, wdata, oh, eb);
      end
      tick();
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_full();
    req   = 3'b100;
    valid = 3'b100;
    last  = 3'b100;
    data[23:16] = 8'h5A;
    full  = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (wr !== 1'b0 || ack !== 3'b000 || grant !== 3'b100) begin
        bad++;
        $display("FAIL full_stall%0d: wr=%b ack=%b grant=%b want 0 000 100",
                 i, wr, ack, grant);
      end
      tick();
    end
    full = 1'b0;
    @(negedge clk);
    total++;
    if ({wr, wdata} !== {1'b1, 8'h5A} || ack !== 3'b100) begin
      bad++;
      $display("FAIL full_release: wr=%b data=%h ack=%b want 1 5a 100",
               wr, wdata, ack);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    total++;
    if (tx_start !== 1'b1 || frame_len !== 16'd1) begin
      bad++;
      $display("FAIL full_start: start=%b len=%0d want 1 1",
               tx_start, frame_len);
    end
    tick();
    tick();
  endtask

  task automatic test_timeout();
    bit saw_start;
    saw_start = 1'b0;
    req   = 3'b001;
    valid = 3'b000;
    tick();
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      total++;
      if (grant !== 3'b001 || timeout !== 1'b0) begin
        bad++;
        $display("FAIL to_hold%0d: grant=%b timeout=%b want 001 0",
                 i, grant, timeout);
      end
      if (tx_start) saw_start = 1'b1;
      tick();
    end
    req = 3'b000;
    @(negedge clk);
    total++;
    if (timeout !== 1'b1 || grant !== 3'b000) begin
      bad++;
      $display("FAIL to_pulse: timeout=%b grant=%b want 1 000",
               timeout, grant);
    end
    if (tx_start) saw_start = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if (timeout !== 1'b0 || tx_start !== 1'b0 || saw_start) begin
      bad++;
      $display("FAIL to_after: timeout=%b start=%b seen_start=%b want 0 0 0",
               timeout, tx_start, saw_start);
    end
    tick();
  endtask

  task automatic test_abort();
    req   = 3'b110;
    valid = 3'b010;
    last  = 3'b000;
    data[15:8] = 8'h11;
    tick();
    @(negedge clk);
    total++;
    if ({wr, wdata} !== {1'b1, 8'h11} || ack !== 3'b010) begin
      bad++;
      $display("FAIL abort_b0: wr=%b data=%h ack=%b want 1 11 010",
               wr, wdata, ack);
    end
    tick();
    data[15:8] = 8'h22;
    @(negedge clk);
    total++;
    if ({wr, wdata} !== {1'b1, 8'h22}) begin
      bad++;
      $display("FAIL abort_b1: wr=%b data=%h want 1 22", wr, wdata);
    end
    tick();
    req = 3'b100;
    data[15:8] = 8'h33;
    @(negedge clk);
    total++;
    if (wr !== 1'b0 || ack !== 3'b000) begin
      bad++;
      $display("FAIL abort_drop: wr=%b ack=%b want 0 000", wr, ack);
    end
    tick();
    @(negedge clk);
    total++;
    if (grant !== 3'b000 || tx_start !== 1'b0 || frame_len !== 16'd2
        || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_release: grant=%b start=%b len=%0d busy=%b want 000 0 2 0",
               grant, tx_start, frame_len, busy);
    end
    tick();
    @(negedge clk);
    total++;
    if (grant !== 3'b100 || frame_len !== 16'd0) begin
      bad++;
      $display("FAIL abort_next: grant=%b len=%0d want 100 0",
               grant, frame_len);
    end
    tick();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    req   = 3'b111;
    valid = 3'b001;
    last  = 3'b000;
    data[7:0] = 8'h77;
    tick();
    tick();
    tick();
    total++;
    if (frame_len !== 16'd2 || grant !== 3'b001 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rmid_pre: len=%0d grant=%b busy=%b want 2 001 1",
               frame_len, grant, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (grant !== 3'b000 || busy !== 1'b0 || frame_len !== 16'd0
        || wr !== 1'b0 || ack !== 3'b000 || tx_start !== 1'b0) begin
      bad++;
      $display("FAIL rmid_clear: grant=%b busy=%b len=%0d wr=%b ack=%b start=%b want all 0",
               grant, busy, frame_len, wr, ack, tx_start);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (grant !== 3'b000 || tx_start !== 1'b0) begin
      bad++;
      $display("FAIL rmid_idle: grant=%b start=%b want 000 0",
               grant, tx_start);
    end
    tick();
    @(negedge clk);
    total++;
    if (grant !== 3'b001) begin
      bad++;
      $display("FAIL rmid_regrant: grant=%b want 001", grant);
    end
    tick();
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_random();
    int rem [3];
    int lastm;
    int nt;
    int starts;
    int tos;
    int stall;
    int k;
    int ek;
    bit got;
    bit force_go;
    logic [7:0] eb;
    logic [2:0] ack_s;
    do_reset();
    nt = 0;
    for (int r = 0; r < N; r++) begin
      nf[r]  = $urandom_range(2, 4);
      rem[r] = nf[r];
      fi[r]  = 0;
      bi[r]  = 0;
      nt += nf[r];
      for (int f = 0; f < 4; f++) begin
        flen[r][f] = $urandom_range(1, 4);
        for (int b = 0; b < 4; b++) fb[r][f][b] = 8'($urandom);
      end
    end
    exp_b.delete();
    exp_k.delete();
    exp_len.delete();
    // Whole frames go out round-robin among requesters with frames left.
    lastm = N - 1;
    for (int n = 0; n < nt; n++) begin
      got = 1'b0;
      for (int i = 1; i <= N; i++) begin
        k = (lastm + i) % N;
        if (!got && rem[k] > 0) begin
          got = 1'b1;
          for (int b = 0; b < flen[k][nf[k]-rem[k]]; b++) begin
            exp_b.push_back(fb[k][nf[k]-rem[k]][b]);
            exp_k.push_back(k);
          end
          exp_len.push_back(flen[k][nf[k]-rem[k]]);
          rem[k]--;
          lastm = k;
        end
      end
    end
    starts = 0;
    tos    = 0;
    stall  = 0;
    for (int cyc = 0; cyc < 3000 && starts < nt; cyc++) begin
      force_go = (stall >= 3);
      full = force_go ? 1'b0 : ($urandom_range(0, 3) == 0);
      for (int r = 0; r < N; r++) begin
        req[r]   = (fi[r] < nf[r]);
        valid[r] = force_go ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (fi[r] < nf[r]) begin
          data[r*8 +: 8] = fb[r][fi[r]][bi[r]];
          last[r] = (bi[r] == flen[r][fi[r]] - 1);
        end else begin
          data[r*8 +: 8] = 8'h00;
          last[r] = 1'b0;
        end
      end
      @(negedge clk);
      if (wr) begin
        stall = 0;
        total++;
        if (exp_b.size() == 0) begin
          bad++;
          $display("FAIL rand_extra: unexpected write data=%h ack=%b",
                   wdata, ack);
        end else begin
          eb = exp_b.pop_front();
          ek = exp_k.pop_front();
          if (wdata !== eb || ack !== (3'b001 << ek) || full) begin
            bad++;
            $display("FAIL rand_byte: data=%h ack=%b full=%b want %h %b 0",
                     wdata, ack, full, eb, 3'b001 << ek);
          end
        end
      end else begin
        stall++;
      end
      if (tx_start) begin
        starts++;
        total++;
        if (exp_len.size() == 0) begin
          bad++;
          $display("FAIL rand_start: extra tx_start len=%0d", frame_len);
        end else begin
          if (frame_len !== 16'(exp_len[0])) begin
            bad++;
            $display("FAIL rand_len: got %0d want %0d",
                     frame_len, exp_len[0]);
          end
          void'(exp_len.pop_front());
        end
      end
      if (timeout) tos++;
      ack_s = ack;
      tick();
      for (int r = 0; r < N; r++) begin
        if (ack_s[r]) begin
          bi[r]++;
          if (bi[r] == flen[r][fi[r]]) begin
            bi[r] = 0;
            fi[r]++;
          end
        end
      end
    end
    idle_inputs();
    total++;
    if (starts != nt || exp_b.size() != 0 || tos != 0) begin
      bad++;
      $display("FAIL rand_end: frames=%0d want %0d left_bytes=%0d timeouts=%0d want 0",
               starts, nt, exp_b.size(), tos);
    end
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
